// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {pc, inst}
// pairs with first-word-fall-through head, flush on redirect, early full.
module inst_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush_i,
  input  logic              we_i,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       pc_i,
  output logic              full_o,
  input  logic              re_i,
  output logic              valid_o,
  output logic [31:0]       inst_o,
  output logic [31:0]       pc_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_HI  = (ADDR_W+1)'(DEPTH - 1);

  logic [63:0]       mem [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;
  logic              push;
  logic              pop;

  // Handshake: a pop happens when re_i is high and valid_o is high; a push
  // happens when we_i is high and there is room (or a pop frees a slot).
  // Both only count while rdy is high and flush_i is low. full_o is raised
  // at DEPTH-1 because fetch commits to a write one cycle after sampling it.
  assign valid_o        = (count != '0);
  assign {pc_o, inst_o} = mem[head];
  assign full_o         = (count >= CNT_HI);
  assign count_o        = count;

  assign pop  = rdy && !flush_i && re_i && valid_o;
  assign push = rdy && !flush_i && we_i && ((count < CNT_MAX) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush_i) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset; entries are only observed while valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= {pc_i, inst_i};
  end

endmodule
